sobel_edge_core: RTL and testbench

- Parametrised 3x3 Sobel edge detector. It takes three vertically adjacent pixel rows (din1 = top, din3 = bottom) from the upstream line-buffer stage and produces one edge pixel per accepted input pixel.
- Adds the following over the previous generation:
  - configurable data width and frame size;
  - frame and line tracking, with border suppression;
  - selectable magnitude and threshold modes;
  - an aligned valid/eol/eof sideband for the downstream stage.

---
 rtl/sobel_edge_core.sv | 167 ++++++++++++++++
 tb/tb_sobel_edge_core.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge_core.sv
// 3x3 Sobel edge detector over streamed pixel columns, with frame/line tracking and border suppression.
// Latency: 3 cycles from the accepting edge to valid_out. Backpressure: none; the pipeline is free-running.
module sobel_edge_core #(
   parameter int DATA_WIDTH = 8,
   parameter int PIC_WIDTH  = 250,
   parameter int PIC_HEIGHT = 250
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sof_in,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] din1,
   input  logic [DATA_WIDTH-1:0] din2,
   input  logic [DATA_WIDTH-1:0] din3,
   input  logic [1:0]            mode,
   input  logic [DATA_WIDTH-1:0] thresh,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  valid_out,
   output logic                  eol_out,
   output logic                  eof_out
);
   localparam int W  = DATA_WIDTH;
   localparam int W2 = W + 2;
   localparam int CW = (PIC_WIDTH  > 1) ? $clog2(PIC_WIDTH)  : 1;
   localparam int RW = (PIC_HEIGHT > 1) ? $clog2(PIC_HEIGHT) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(PIC_HEIGHT - 1);
   localparam logic [W+3:0]  SAT      = {4'b0, {W{1'b1}}};

   logic [CW-1:0]        r_col;
   logic [RW-1:0]        r_row;
   logic [1:0]           r_mode_sh;
   logic [W-1:0]         r_thr_sh;
   logic [2:0][W-1:0]    r_t, r_m, r_b;
   logic                 r_v1, r_bdr1, r_eol1, r_eof1;
   logic [1:0]           r_mode1;
   logic [W-1:0]         r_thr1;
   logic signed [W+2:0]  r_gx, r_gy;
   logic [W-1:0]         r_c2, r_thr2;
   logic                 r_v2, r_bdr2, r_eol2, r_eof2;
   logic [1:0]           r_mode2;
   logic [W+3:0]         r_l1, r_alt;
   logic [W-1:0]         r_c3, r_thr3;
   logic                 r_v3, r_bdr3, r_eol3, r_eof3;
   logic [1:0]           r_mode3;

   logic [CW-1:0]        w_col;
   logic [RW-1:0]        w_row;
   logic                 w_first, w_eol, w_eof, w_border;
   logic [1:0]           w_mode_eff;
   logic [W-1:0]         w_thr_eff;
   logic [W+1:0]         w_gx_p, w_gx_n, w_gy_p, w_gy_n;
   logic signed [W+2:0]  w_gx, w_gy;
   logic [W+1:0]         w_ax, w_ay, w_mx, w_mn;
   logic [W-1:0]         w_dout;

   // sof_in only matters on an accepted pixel; it restarts the position at the frame origin
   assign w_col      = sof_in ? '0 : r_col;
   assign w_row      = sof_in ? '0 : r_row;
   assign w_first    = (w_col == '0) && (w_row == '0);
   assign w_eol      = (w_col == COL_LAST);
   assign w_eof      = w_eol && (w_row == ROW_LAST);
   assign w_border   = (int'(w_col) < 2) || (int'(w_row) < 2);
   assign w_mode_eff = w_first ? mode   : r_mode_sh;
   assign w_thr_eff  = w_first ? thresh : r_thr_sh;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col     <= '0;
         r_row     <= '0;
         r_mode_sh <= '0;
         r_thr_sh  <= '0;
      end else if (valid_in) begin
         if (w_eol) begin
            r_col <= '0;
            r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
         end else begin
            r_col <= w_col + 1'b1;
            r_row <= w_row;
         end
         if (w_first) begin
            r_mode_sh <= mode;
            r_thr_sh  <= thresh;
         end
      end
   end

   // Index 0 is the newest column c, index 2 the oldest column c-2
   assign w_gx_p = {2'b0, r_t[0]} + {1'b0, r_m[0], 1'b0} + {2'b0, r_b[0]};
   assign w_gx_n = {2'b0, r_t[2]} + {1'b0, r_m[2], 1'b0} + {2'b0, r_b[2]};
   assign w_gy_p = {2'b0, r_t[0]} + {1'b0, r_t[1], 1'b0} + {2'b0, r_t[2]};
   assign w_gy_n = {2'b0, r_b[0]} + {1'b0, r_b[1], 1'b0} + {2'b0, r_b[2]};
   assign w_gx   = $signed({1'b0, w_gx_p}) - $signed({1'b0, w_gx_n});
   assign w_gy   = $signed({1'b0, w_gy_p}) - $signed({1'b0, w_gy_n});

   assign w_ax = r_gx[W+2] ? W2'(-r_gx) : W2'(r_gx);
   assign w_ay = r_gy[W+2] ? W2'(-r_gy) : W2'(r_gy);
   assign w_mx = (w_ax > w_ay) ? w_ax : w_ay;
   assign w_mn = (w_ax > w_ay) ? w_ay : w_ax;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_t <= '0; r_m <= '0; r_b <= '0;
         r_v1 <= 1'b0; r_bdr1 <= 1'b0; r_eol1 <= 1'b0; r_eof1 <= 1'b0;
         r_mode1 <= '0; r_thr1 <= '0;
         r_gx <= '0; r_gy <= '0; r_c2 <= '0; r_thr2 <= '0; r_mode2 <= '0;
         r_v2 <= 1'b0; r_bdr2 <= 1'b0; r_eol2 <= 1'b0; r_eof2 <= 1'b0;
         r_l1 <= '0; r_alt <= '0; r_c3 <= '0; r_thr3 <= '0; r_mode3 <= '0;
         r_v3 <= 1'b0; r_bdr3 <= 1'b0; r_eol3 <= 1'b0; r_eof3 <= 1'b0;
      end else begin
         r_v1 <= valid_in;
         if (valid_in) begin
            r_t     <= {r_t[1:0], din1};
            r_m     <= {r_m[1:0], din2};
            r_b     <= {r_b[1:0], din3};
            r_bdr1  <= w_border;
            r_eol1  <= w_eol;
            r_eof1  <= w_eof;
            r_mode1 <= w_mode_eff;
            r_thr1  <= w_thr_eff;
         end
         r_v2    <= r_v1;
         r_gx    <= w_gx;
         r_gy    <= w_gy;
         r_c2    <= r_m[1];
         r_bdr2  <= r_bdr1;
         r_eol2  <= r_eol1;
         r_eof2  <= r_eof1;
         r_mode2 <= r_mode1;
         r_thr2  <= r_thr1;
         r_v3    <= r_v2;
         r_l1    <= {2'b0, w_ax} + {2'b0, w_ay};
         r_alt   <= {2'b0, w_mx} + {2'b0, (w_mn >> 1)};
         r_c3    <= r_c2;
         r_bdr3  <= r_bdr2;
         r_eol3  <= r_eol2;
         r_eof3  <= r_eof2;
         r_mode3 <= r_mode2;
         r_thr3  <= r_thr2;
      end
   end

   always_comb begin
      w_dout = '0;
      case (r_mode3)
         2'd0:    w_dout = (r_l1  > SAT) ? '1 : r_l1[W-1:0];
         2'd1:    w_dout = (r_alt > SAT) ? '1 : r_alt[W-1:0];
         2'd2:    w_dout = (r_l1 >= {4'b0, r_thr3}) ? '1 : '0;
         default: w_dout = r_c3;
      endcase
      if (r_bdr3) w_dout = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout      <= '0;
         valid_out <= 1'b0;
         eol_out   <= 1'b0;
         eof_out   <= 1'b0;
      end else begin
         valid_out <= r_v3;
         eol_out   <= r_v3 & r_eol3;
         eof_out   <= r_v3 & r_eof3;
         if (r_v3) dout <= w_dout;
      end
   end
endmodule

// File: tb/tb_sobel_edge_core.sv
// Bench for sobel_edge_core: table of frame patterns with hand-derived interior results, scoreboard queue
// filled at drive time and drained as valid_out appears, plus mid-frame sof and async-reset sequences.
module tb_sobel_edge_core;
   localparam int W    = 8;
   localparam int PW   = 8;
   localparam int PH   = 4;
   localparam int NREC = 16;

   logic         clk = 1'b0, rst = 1'b0, sof_in = 1'b0, valid_in = 1'b0;
   logic [W-1:0] din1 = '0, din2 = '0, din3 = '0, thresh = '0;
   logic [1:0]   mode = '0;
   logic [W-1:0] dout;
   logic         valid_out, eol_out, eof_out;

   always #5 clk = ~clk;

   sobel_edge_core #(.DATA_WIDTH(W), .PIC_WIDTH(PW), .PIC_HEIGHT(PH)) dut (
      .clk(clk), .rst(rst), .sof_in(sof_in), .valid_in(valid_in),
      .din1(din1), .din2(din2), .din3(din3), .mode(mode), .thresh(thresh),
      .dout(dout), .valid_out(valid_out), .eol_out(eol_out), .eof_out(eof_out)
   );

   // kind 0: each row t/m/b = base + step*col; kind 1: vertical step 0 | 255 at col 4.
   // Interior (col>=2,row>=2) result = eb + es*col; kind 1 uses its own step table.
   typedef struct {
      int kind;
      int t0, dt, m0, dm, b0, db;
      int mode, thr, gaps;
      int eb, es;
   } rec_t;

   typedef struct packed {
      logic [W-1:0] d;
      logic         eol;
      logic         eof;
   } exp_t;

   rec_t         tbl [NREC];
   exp_t         exp_q [$];
   int           acc_q [$];
   int           cyc = 0;
   int           n_chk = 0;
   int           n_err = 0;
   logic [W-1:0] last_dout = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic send_pix(input int t, input int m, input int b, input logic sof, input logic first,
                           input int md, input int thr, input int ed, input logic eol, input logic eof);
      exp_t e;
      @(negedge clk);
      valid_in = 1'b1;
      sof_in   = sof;
      din1     = W'(t);
      din2     = W'(m);
      din3     = W'(b);
      // Off-origin pixels carry a different mode/threshold that must not be captured
      mode     = first ? 2'(md) : 2'((md + 1 + $urandom_range(0, 2)) % 4);
      thresh   = first ? W'(thr) : W'($urandom_range(0, 255));
      e.d = W'(ed);
      e.eol = eol;
      e.eof = eof;
      exp_q.push_back(e);
      acc_q.push_back(cyc + 1);
   endtask

   task automatic idle();
      @(negedge clk);
      valid_in = 1'b0;
      sof_in   = 1'b1;
      din1     = W'($urandom);
      din2     = W'($urandom);
      din3     = W'($urandom);
      mode     = 2'($urandom);
      thresh   = W'($urandom);
   endtask

   task automatic run_frame(input int k, input int npix, input bit use_sof);
      rec_t r;
      r = tbl[k];
      for (int i = 0; i < npix; i++) begin
         int c, rw, t, m, b, ed;
         c  = i % PW;
         rw = i / PW;
         if (r.kind == 1) begin
            t = (c >= 4) ? 255 : 0;
            m = t;
            b = t;
         end else begin
            t = r.t0 + r.dt * c;
            m = r.m0 + r.dm * c;
            b = r.b0 + r.db * c;
         end
         if (c < 2 || rw < 2)  ed = 0;
         else if (r.kind == 1) ed = (c == 4 || c == 5) ? 255 : 0;
         else                  ed = r.eb + r.es * c;
         send_pix(t, m, b, use_sof && (i == 0), (i == 0), r.mode, r.thr, ed,
                  (c == PW - 1), (c == PW - 1) && (rw == PH - 1));
         if (r.gaps > 0 && (c == 3 || c == 6)) repeat (r.gaps) idle();
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         last_dout = '0;
      end else if (valid_out) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid_out", 1, 0);
         end else begin
            exp_t e;
            int   a;
            e = exp_q.pop_front();
            a = acc_q.pop_front();
            check("dout", int'(dout), int'(e.d));
            check("eol_out", int'(eol_out), int'(e.eol));
            check("eof_out", int'(eof_out), int'(e.eof));
            check("latency", cyc - a, 3);
         end
         last_dout = dout;
      end else begin
         check("idle_hold", int'({dout, eol_out, eof_out}), int'({last_dout, 2'b00}));
      end
   end

   initial begin
      //            kind t0  dt  m0  dm   b0  db mode thr gaps eb   es
      tbl[0]  = '{0, 100, 0, 100,   0, 100, 0, 0,   0, 0,   0,   0};
      tbl[1]  = '{1,   0, 0,   0,   0,   0, 0, 0,   0, 0,   0,   0};
      tbl[2]  = '{1,   0, 0,   0,   0,   0, 0, 0,   0, 3,   0,   0};
      tbl[3]  = '{0,  60, 0,  40,   0,  20, 0, 0,   0, 0, 160,   0};
      tbl[4]  = '{0,  60, 0,  40,   0,  20, 0, 1,   0, 0, 160,   0};
      tbl[5]  = '{0,  60, 0,  40,   0,  20, 0, 2, 150, 0, 255,   0};
      tbl[6]  = '{0,  60, 0,  40,   0,  20, 0, 2, 161, 0,   0,   0};
      tbl[7]  = '{0,  60, 0,   0,  10,  20, 0, 0,   0, 0, 200,   0};
      tbl[8]  = '{0,  60, 0,   0,  10,  20, 0, 1,   0, 0, 180,   0};
      tbl[9]  = '{0,  60, 0,   0,  10,  20, 0, 2, 200, 0, 255,   0};
      tbl[10] = '{0,  60, 0,   0,  10,  20, 0, 2, 201, 0,   0,   0};
      tbl[11] = '{0,  60, 0,   0,  10,  20, 0, 3,   0, 0, -10,  10};
      tbl[12] = '{0,  20, 0, 100, -10,  60, 0, 1,   0, 0, 180,   0};
      tbl[13] = '{0,  20, 0, 100, -10,  60, 0, 0,   0, 0, 200,   0};
      tbl[14] = '{0, 255, 0,   0,   0,   0, 0, 1,   0, 0, 255,   0};
      tbl[15] = '{0, 255, 0,   0,   0,   0, 0, 0,   0, 2, 255,   0};

      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_outputs", int'({dout, valid_out, eol_out, eof_out}), 0);
      rst = 1'b0;

      for (int k = 0; k < NREC; k++) run_frame(k, PW * PH, 1'b1);

      // sof_in at row 2, col 5 restarts the frame at the origin
      run_frame(3, 21, 1'b1);
      run_frame(9, PW * PH, 1'b1);

      // Reset with two results still in flight, then a frame without sof_in
      run_frame(3, 22, 1'b1);
      idle();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_reset_outputs", int'({dout, valid_out, eol_out, eof_out}), 0);
      exp_q.delete();
      acc_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      run_frame(8, PW * PH, 1'b0);

      repeat (10) idle();
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
